// File: rtl/vlsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vlsu_pkg
//  Purpose  : Shared types, widths and nibble index mapping for the VLSU
//             shuffle stage (sequential beat -> per-lane layout).
//  Revision : 1.0  initial release
// ============================================================================
package vlsu_pkg;

  // Default configuration used to build the default payload types
  localparam int unsigned DEF_NR_LANES = 4;
  localparam int unsigned DEF_DLEN     = 64;
  localparam int unsigned DEF_LANE_NB  = DEF_DLEN / 4;
  localparam int unsigned DEF_NB       = DEF_NR_LANES * DEF_LANE_NB;

  // Vector-memory SRAM set space and tag widths
  localparam int unsigned vmSramDepth = 16;
  localparam int unsigned SET_W       = $clog2(vmSramDepth);
  localparam int unsigned OFF_W       = 4;
  localparam int unsigned REQ_ID_W    = 4;
  localparam int unsigned CMT_W       = 8;

  typedef enum logic [0:0] {
    SHF_SEQ = 1'b0,  // element-interleaved shuffle, element width from eew
    SHF_COL = 1'b1   // 2D column mode, nibble-granular transpose
  } shf_mode_e;

  typedef logic [SET_W-1:0] vaddr_set_t;

  typedef struct packed {
    vaddr_set_t       set;
    logic [OFF_W-1:0] off;
  } vaddr_t;

  typedef struct packed {
    logic [REQ_ID_W-1:0] req_id;
    shf_mode_e           mode;
    logic [1:0]          eew;
    logic                vm;
    logic [CMT_W-1:0]    cmt_cnt;
    vaddr_t              vaddr;
  } shf_ctrl_def_t;

  // Working copy of the head entry's mutable fields
  typedef struct packed {
    logic [CMT_W-1:0] cmt_cnt;
    vaddr_set_t       vaddr_set;
  } shf_info_t;

  typedef struct packed {
    logic [DEF_NB-1:0][3:0] nb;
    logic [DEF_NB-1:0]      en;
  } seq_buf_def_t;

  typedef struct packed {
    logic [DEF_DLEN-1:0]   data;
    logic [DEF_LANE_NB-1:0] nbe;
    logic [REQ_ID_W-1:0]   req_id;
    vaddr_set_t            vaddr_set;
    logic [OFF_W-1:0]      vaddr_off;
  } tx_lane_def_t;

  // Next SRAM set, wrapping at the end of the set space
  function automatic vaddr_set_t set_inc(input vaddr_set_t s);
    return (s == SET_W'(vmSramDepth - 1)) ? '0 : s + SET_W'(1);
  endfunction

  // Source nibble index in the sequential beat for output nibble idx
  // (idx = lane * lane_nibbles + nibble). Sequential mode deals whole
  // elements of 2<<eew nibbles round-robin across lanes; column mode
  // deals single nibbles round-robin across lanes.
  function automatic int unsigned shf_idx(input shf_mode_e mode,
                                          input logic [1:0] eew,
                                          input int unsigned idx,
                                          input int unsigned nr_lanes,
                                          input int unsigned dlen);
    int unsigned lane_nb, lane, o, sh, j, b;
    lane_nb = dlen / 4;
    lane    = idx / lane_nb;
    o       = idx % lane_nb;
    if (mode == SHF_COL) return o * nr_lanes + lane;
    sh = {30'd0, eew} + 32'd1;
    j  = o >> sh;
    b  = o & ((32'd1 << sh) - 32'd1);
    return ((j * nr_lanes + lane) << sh) + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vlsu_lane_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vlsu_lane_fifo
//  Purpose  : Per-lane output FIFO, flag+index circular-queue pointers,
//             synchronous flush, payload storage not reset.
//  Revision : 1.0  initial release
// ============================================================================
module vlsu_lane_fifo #(
  parameter int unsigned Depth  = 2,
  parameter type         data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  logic  push_i,
  input  data_t data_i,
  output logic  full_o,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  data_t             r_mem [Depth];
  logic              r_wr_flag, r_rd_flag;
  logic [IdxW-1:0]   r_wr_idx, r_rd_idx;
  logic              w_push, w_pop;

  assign full_o  = (r_wr_flag != r_rd_flag) && (r_wr_idx == r_rd_idx);
  assign valid_o = !((r_wr_flag == r_rd_flag) && (r_wr_idx == r_rd_idx));
  assign data_o  = r_mem[r_rd_idx];
  assign w_push  = push_i && !full_o;
  assign w_pop   = valid_o && ready_i;

  // Pointer update: index wraps at Depth-1 and toggles the lap flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_flag <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_flag <= 1'b0;
      r_rd_idx  <= '0;
    end else if (flush_i) begin
      r_wr_flag <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_flag <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      if (w_push) begin
        if (r_wr_idx == IdxW'(Depth - 1)) begin
          r_wr_idx  <= '0;
          r_wr_flag <= ~r_wr_flag;
        end else begin
          r_wr_idx <= r_wr_idx + IdxW'(1);
        end
      end
      if (w_pop) begin
        if (r_rd_idx == IdxW'(Depth - 1)) begin
          r_rd_idx  <= '0;
          r_rd_flag <= ~r_rd_flag;
        end else begin
          r_rd_idx <= r_rd_idx + IdxW'(1);
        end
      end
    end
  end

  // Payload write, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_idx] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/vlsu_shuffle_stage.sv
`default_nettype none
// ============================================================================
//  Module   : vlsu_shuffle_stage
//  Purpose  : Reorders sequential load beats into per-lane layout, applies
//             element mask, tags each beat with SRAM set/offset from the
//             head shuffle-info entry, and buffers per lane.
//  Revision : 1.0  initial release
// ============================================================================
module vlsu_shuffle_stage
  import vlsu_pkg::*;
#(
  parameter int unsigned NrLanes       = 4,
  parameter int unsigned DLEN          = 64,
  parameter int unsigned InfoDepth     = 4,
  parameter int unsigned LaneFifoDepth = 2,
  parameter bit          DropEmpty     = 1'b1,
  parameter type         shf_ctrl_t    = shf_ctrl_def_t,
  parameter type         seq_buf_t     = seq_buf_def_t,
  parameter type         tx_lane_t     = tx_lane_def_t
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            info_valid_i,
  output logic                            info_ready_o,
  input  shf_ctrl_t                       info_i,
  input  logic                            seq_valid_i,
  output logic                            seq_ready_o,
  input  seq_buf_t                        seq_i,
  input  logic [NrLanes-1:0]              mask_valid_i,
  input  logic [NrLanes-1:0][DLEN/4-1:0]  mask_bits_i,
  output logic                            mask_ready_o,
  output logic [NrLanes-1:0]              txs_valid_o,
  input  logic [NrLanes-1:0]              txs_ready_i,
  output tx_lane_t [NrLanes-1:0]          txs_o,
  input  logic                            flush_i,
  output logic                            busy_o
);

  localparam int unsigned LaneNb   = DLEN / 4;
  localparam int unsigned Nb       = NrLanes * LaneNb;
  localparam int unsigned NbW      = $clog2(Nb);
  localparam int unsigned InfoIdxW = (InfoDepth > 1) ? $clog2(InfoDepth) : 1;

  typedef logic [DLEN/4-1:0] strb_t;

  // Info queue state
  shf_ctrl_t             r_info_mem [InfoDepth];
  logic                  r_enq_flag, r_deq_flag;
  logic [InfoIdxW-1:0]   r_enq_idx, r_deq_idx;
  logic                  w_enq_flag_nxt, w_deq_flag_nxt;
  logic [InfoIdxW-1:0]   w_enq_idx_nxt, w_deq_idx_nxt;
  logic                  w_info_empty, w_info_full;
  logic                  w_enq, w_deq, w_deq_rem, w_load_from_info;
  shf_info_t             r_work;

  // Head entry fields
  shf_mode_e             w_head_mode;
  logic [1:0]            w_head_eew;
  logic                  w_head_vm;
  logic [REQ_ID_W-1:0]   w_head_req_id;
  logic [OFF_W-1:0]      w_head_off;

  // Datapath
  tx_lane_t              w_tx [NrLanes];
  logic [NrLanes-1:0]    w_lane_full;
  logic                  w_any_nbe, w_accept, w_push;

  assign w_info_empty = (r_enq_flag == r_deq_flag) && (r_enq_idx == r_deq_idx);
  assign w_info_full  = (r_enq_flag != r_deq_flag) && (r_enq_idx == r_deq_idx);

  assign w_head_mode   = r_info_mem[r_deq_idx].mode;
  assign w_head_eew    = r_info_mem[r_deq_idx].eew;
  assign w_head_vm     = r_info_mem[r_deq_idx].vm;
  assign w_head_req_id = r_info_mem[r_deq_idx].req_id;
  assign w_head_off    = r_info_mem[r_deq_idx].vaddr.off;

  assign info_ready_o = !w_info_full && !flush_i;
  assign seq_ready_o  = !w_info_empty && !(|w_lane_full) &&
                        (w_head_vm || (&mask_valid_i)) && !flush_i;
  assign w_accept     = seq_valid_i && seq_ready_o;
  assign mask_ready_o = w_accept && !w_head_vm;
  assign w_push       = w_accept && (!DropEmpty || w_any_nbe);
  assign w_enq        = info_valid_i && info_ready_o;
  assign w_deq        = w_accept && (r_work.cmt_cnt == '0);
  assign busy_o       = !w_info_empty || (|txs_valid_o);

  // Entries remaining behind the head once it leaves
  assign w_deq_rem        = {w_deq_flag_nxt, w_deq_idx_nxt} != {r_enq_flag, r_enq_idx};
  assign w_load_from_info = w_enq && (w_info_empty || (w_deq && !w_deq_rem));

  // Next-pointer computation for both queue ends
  always_comb begin
    w_enq_flag_nxt = r_enq_flag;
    w_enq_idx_nxt  = r_enq_idx + InfoIdxW'(1);
    w_deq_flag_nxt = r_deq_flag;
    w_deq_idx_nxt  = r_deq_idx + InfoIdxW'(1);
    if (r_enq_idx == InfoIdxW'(InfoDepth - 1)) begin
      w_enq_idx_nxt  = '0;
      w_enq_flag_nxt = ~r_enq_flag;
    end
    if (r_deq_idx == InfoIdxW'(InfoDepth - 1)) begin
      w_deq_idx_nxt  = '0;
      w_deq_flag_nxt = ~r_deq_flag;
    end
  end

  // Info queue pointers; flush returns the queue to empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_enq_flag <= 1'b0;
      r_enq_idx  <= '0;
      r_deq_flag <= 1'b0;
      r_deq_idx  <= '0;
    end else if (flush_i) begin
      r_enq_flag <= 1'b0;
      r_enq_idx  <= '0;
      r_deq_flag <= 1'b0;
      r_deq_idx  <= '0;
    end else begin
      if (w_enq) begin
        r_enq_flag <= w_enq_flag_nxt;
        r_enq_idx  <= w_enq_idx_nxt;
      end
      if (w_deq) begin
        r_deq_flag <= w_deq_flag_nxt;
        r_deq_idx  <= w_deq_idx_nxt;
      end
    end
  end

  // Info payload storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_enq) r_info_mem[r_enq_idx] <= info_i;
  end

  // Working copy: reloaded when a new entry becomes head, else stepped per beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_work <= '0;
    end else if (flush_i) begin
      r_work <= '0;
    end else if (w_deq && w_deq_rem) begin
      r_work.cmt_cnt   <= r_info_mem[w_deq_idx_nxt].cmt_cnt;
      r_work.vaddr_set <= r_info_mem[w_deq_idx_nxt].vaddr.set;
    end else if (w_load_from_info) begin
      r_work.cmt_cnt   <= info_i.cmt_cnt;
      r_work.vaddr_set <= info_i.vaddr.set;
    end else if (w_accept && !w_deq) begin
      r_work.cmt_cnt   <= r_work.cmt_cnt - CMT_W'(1);
      r_work.vaddr_set <= set_inc(r_work.vaddr_set);
    end
  end

  // Shuffle the sequential beat into lane order and apply the nibble mask
  always_comb begin
    logic [NbW-1:0] k;
    strb_t          m;
    k         = '0;
    m         = '0;
    w_any_nbe = 1'b0;
    for (int unsigned l = 0; l < NrLanes; l++) begin
      w_tx[l] = '0;
      m       = mask_bits_i[l];
      for (int unsigned o = 0; o < LaneNb; o++) begin
        k = NbW'(shf_idx(w_head_mode, w_head_eew, l * LaneNb + o, NrLanes, DLEN));
        w_tx[l].data[o*4 +: 4] = seq_i.nb[k];
        w_tx[l].nbe[o]         = seq_i.en[k] & (w_head_vm | m[o]);
      end
      w_tx[l].req_id    = w_head_req_id;
      w_tx[l].vaddr_set = r_work.vaddr_set;
      w_tx[l].vaddr_off = w_head_off;
      w_any_nbe         = w_any_nbe | (|w_tx[l].nbe);
    end
  end

  for (genvar g = 0; g < NrLanes; g++) begin : g_lane
    vlsu_lane_fifo #(
      .Depth  (LaneFifoDepth),
      .data_t (tx_lane_t)
    ) i_lane_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (w_push),
      .data_i  (w_tx[g]),
      .full_o  (w_lane_full[g]),
      .valid_o (txs_valid_o[g]),
      .ready_i (txs_ready_i[g]),
      .data_o  (txs_o[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_vlsu_shuffle_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vlsu_shuffle_stage
//  Purpose  : Directed self-checking bench for vlsu_shuffle_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vlsu_shuffle_stage;
  import vlsu_pkg::*;

  localparam int NL = 4;

  logic                    clk = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    info_valid = 1'b0;
  logic                    info_ready_o;
  shf_ctrl_def_t           info_in = '0;
  logic                    seq_valid = 1'b0;
  logic                    seq_ready_o;
  seq_buf_def_t            seq_in = '0;
  logic [NL-1:0]           mask_valid = '0;
  logic [NL-1:0][15:0]     mask_bits = '0;
  logic                    mask_ready_o;
  logic [NL-1:0]           txs_valid_o;
  logic [NL-1:0]           txs_ready = '1;
  tx_lane_def_t [NL-1:0]   txs_o;
  logic                    flush = 1'b0;
  logic                    busy_o;

  int errors = 0;
  int checks = 0;

  vlsu_shuffle_stage #(
    .NrLanes(4), .DLEN(64), .InfoDepth(4), .LaneFifoDepth(2), .DropEmpty(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .info_valid_i(info_valid), .info_ready_o(info_ready_o), .info_i(info_in),
    .seq_valid_i(seq_valid), .seq_ready_o(seq_ready_o), .seq_i(seq_in),
    .mask_valid_i(mask_valid), .mask_bits_i(mask_bits), .mask_ready_o(mask_ready_o),
    .txs_valid_o(txs_valid_o), .txs_ready_i(txs_ready), .txs_o(txs_o),
    .flush_i(flush), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Forward model: place each source element/nibble into its lane slot
  function automatic logic [63:0] exp_data(input seq_buf_def_t b, input logic col,
                                           input logic [1:0] eew, input int lane);
    logic [63:0] d;
    int ew;
    d = '0;
    if (col) begin
      for (int k = 0; k < 64; k++)
        if (k % NL == lane) d[(k / NL) * 4 +: 4] = b.nb[k];
    end else begin
      ew = 2 << eew;
      for (int e = 0; e < 64 / ew; e++)
        if (e % NL == lane)
          for (int x = 0; x < ew; x++) d[((e / NL) * ew + x) * 4 +: 4] = b.nb[e * ew + x];
    end
    return d;
  endfunction

  function automatic seq_buf_def_t make_beat(input bit en_on);
    seq_buf_def_t b;
    for (int k = 0; k < 64; k++) begin
      b.nb[k] = 4'($urandom);
      b.en[k] = en_on;
    end
    return b;
  endfunction

  // Drive one info entry (called at a negedge); ok=0 if never accepted
  task automatic push_info(input logic [3:0] id, input logic col, input logic [1:0] eew,
                           input logic vm, input logic [7:0] cmt, input logic [3:0] set,
                           input logic [3:0] off, output bit ok);
    info_in.req_id    = id;
    info_in.mode      = col ? SHF_COL : SHF_SEQ;
    info_in.eew       = eew;
    info_in.vm        = vm;
    info_in.cmt_cnt   = cmt;
    info_in.vaddr.set = set;
    info_in.vaddr.off = off;
    info_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (info_ready_o) begin ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    @(negedge clk);
    info_valid = 1'b0;
  endtask

  // Drive one beat (called at a negedge); returns at the negedge after accept
  task automatic send_beat(input seq_buf_def_t b, output bit ok);
    seq_in = b;
    seq_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (seq_ready_o) begin ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    @(negedge clk);
    seq_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (txs_valid_o !== 4'h0) begin errors++; $display("FAIL reset_txs_valid: got %b want 0000", txs_valid_o); end
    checks++; if (seq_ready_o !== 1'b0) begin errors++; $display("FAIL reset_seq_ready: got %b want 0", seq_ready_o); end
    checks++; if (mask_ready_o !== 1'b0) begin errors++; $display("FAIL reset_mask_ready: got %b want 0", mask_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    rst_ni = 1'b1;
    @(negedge clk);
    checks++; if (info_ready_o !== 1'b1) begin errors++; $display("FAIL reset_info_ready: got %b want 1", info_ready_o); end
  endtask

  task automatic test_basic;
    bit ok;
    seq_buf_def_t b;
    txs_ready = 4'hF;
    push_info(4'd1, 1'b0, 2'd0, 1'b1, 8'd3, 4'd10, 4'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_info_accept: got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      b = make_beat(1'b1);
      send_beat(b, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_accept beat%0d: got 0 want 1", i); end
      checks++; if (txs_valid_o !== 4'hF) begin errors++; $display("FAIL basic_valid beat%0d: got %b want 1111", i, txs_valid_o); end
      for (int l = 0; l < NL; l++) begin
        checks++;
        if (txs_o[l].vaddr_set !== 4'(10 + i) || txs_o[l].req_id !== 4'd1 || txs_o[l].vaddr_off !== 4'd5)
          begin errors++; $display("FAIL basic_tag lane%0d beat%0d: got set %0d id %0d off %0d want set %0d id 1 off 5",
                                   l, i, txs_o[l].vaddr_set, txs_o[l].req_id, txs_o[l].vaddr_off, 10 + i); end
        checks++;
        if (txs_o[l].data !== exp_data(b, 1'b0, 2'd0, l))
          begin errors++; $display("FAIL basic_data lane%0d beat%0d: got %h want %h", l, i, txs_o[l].data, exp_data(b, 1'b0, 2'd0, l)); end
      end
      // Byte elements: lane 1 starts with source element 1 = nibbles 2,3
      if (i == 0) begin
        checks++; if (txs_o[1].data[3:0] !== b.nb[2]) begin errors++; $display("FAIL basic_lane1_nib0: got %h want %h", txs_o[1].data[3:0], b.nb[2]); end
      end
      #1;
      if (i == 2) begin
        checks++; if (seq_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_after3: got %b want 1", seq_ready_o); end
      end
      if (i == 3) begin
        checks++; if (seq_ready_o !== 1'b0) begin errors++; $display("FAIL basic_dequeued: seq_ready got %b want 0", seq_ready_o); end
      end
    end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle: busy got %b want 0", busy_o); end
  endtask

  task automatic test_shuffle;
    bit ok;
    seq_buf_def_t b;
    logic [3:0] ids [4] = '{4'd9, 4'd10, 4'd11, 4'd12};
    logic       cols [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] eews [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 4; i++) begin
      push_info(ids[i], cols[i], eews[i], 1'b1, 8'd0, 4'(i), 4'd0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL shuffle_info_accept %0d: got 0 want 1", i); end
    end
    #1;
    checks++; if (info_ready_o !== 1'b0) begin errors++; $display("FAIL shuffle_queue_full: info_ready got %b want 0", info_ready_o); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b = make_beat(1'b1);
      send_beat(b, ok);
      checks++; if (!ok) begin errors++; $display("FAIL shuffle_accept %0d: got 0 want 1", i); end
      for (int l = 0; l < NL; l++) begin
        checks++;
        if (txs_o[l].data !== exp_data(b, cols[i], eews[i], l) || txs_o[l].req_id !== ids[i])
          begin errors++; $display("FAIL shuffle_data mode%0d lane%0d: got %h id %0d want %h id %0d",
                                   i, l, txs_o[l].data, txs_o[l].req_id, exp_data(b, cols[i], eews[i], l), ids[i]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok;
    seq_buf_def_t ba, bb, bc, bd;
    txs_ready = 4'b1011;
    push_info(4'd2, 1'b0, 2'd0, 1'b1, 8'd3, 4'd0, 4'd0, ok);
    ba = make_beat(1'b1); bb = make_beat(1'b1); bc = make_beat(1'b1); bd = make_beat(1'b1);
    send_beat(ba, ok);
    send_beat(bb, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_two_accepts: got 0 want 1"); end
    seq_in = bc; seq_valid = 1'b1;
    #1;
    checks++; if (seq_ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall: seq_ready got %b want 0", seq_ready_o); end
    repeat (2) @(negedge clk);
    checks++; if (txs_valid_o !== 4'b0100) begin errors++; $display("FAIL bp_drain: txs_valid got %b want 0100", txs_valid_o); end
    checks++;
    if (txs_o[2].vaddr_set !== 4'd0 || txs_o[2].data !== exp_data(ba, 1'b0, 2'd0, 2))
      begin errors++; $display("FAIL bp_lane2_head: got set %0d data %h want set 0 data %h", txs_o[2].vaddr_set, txs_o[2].data, exp_data(ba, 1'b0, 2'd0, 2)); end
    txs_ready = 4'hF;
    send_beat(bc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_resume: got 0 want 1"); end
    checks++;
    if (txs_valid_o !== 4'hF || txs_o[2].vaddr_set !== 4'd2 || txs_o[0].vaddr_set !== 4'd2)
      begin errors++; $display("FAIL bp_after_resume: got valid %b set %0d/%0d want 1111 set 2/2", txs_valid_o, txs_o[2].vaddr_set, txs_o[0].vaddr_set); end
    send_beat(bd, ok);
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_idle: busy got %b want 0", busy_o); end
  endtask

  task automatic test_mask;
    bit ok;
    seq_buf_def_t b;
    txs_ready = 4'hF;
    push_info(4'd3, 1'b0, 2'd1, 1'b0, 8'd0, 4'd3, 4'd0, ok);
    b = make_beat(1'b1);
    seq_in = b; seq_valid = 1'b1;
    mask_valid = 4'b0111;
    mask_bits[0] = 16'h0000; mask_bits[1] = 16'hFFFF; mask_bits[2] = 16'hFFFF; mask_bits[3] = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (seq_ready_o !== 1'b0 || mask_ready_o !== 1'b0)
        begin errors++; $display("FAIL mask_partial cyc%0d: got ready %b mready %b want 0 0", c, seq_ready_o, mask_ready_o); end
      @(negedge clk);
    end
    checks++; if (txs_valid_o !== 4'h0) begin errors++; $display("FAIL mask_no_push: got %b want 0000", txs_valid_o); end
    mask_valid = 4'hF;
    #1;
    checks++; if (mask_ready_o !== 1'b1) begin errors++; $display("FAIL mask_ready_pulse: got %b want 1", mask_ready_o); end
    @(posedge clk);
    @(negedge clk);
    seq_valid = 1'b0; mask_valid = 4'h0;
    #1;
    checks++; if (mask_ready_o !== 1'b0) begin errors++; $display("FAIL mask_ready_single: got %b want 0", mask_ready_o); end
    checks++; if (txs_valid_o !== 4'hF) begin errors++; $display("FAIL mask_valid_out: got %b want 1111", txs_valid_o); end
    checks++;
    if (txs_o[0].nbe !== 16'h0000 || txs_o[1].nbe !== 16'hFFFF)
      begin errors++; $display("FAIL mask_nbe: got lane0 %h lane1 %h want 0000 ffff", txs_o[0].nbe, txs_o[1].nbe); end
    checks++;
    if (txs_o[3].data !== exp_data(b, 1'b0, 2'd1, 3))
      begin errors++; $display("FAIL mask_data lane3: got %h want %h", txs_o[3].data, exp_data(b, 1'b0, 2'd1, 3)); end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    bit ok;
    push_info(4'd4, 1'b0, 2'd0, 1'b1, 8'd1, 4'd15, 4'd0, ok);
    send_beat(make_beat(1'b1), ok);
    checks++; if (txs_o[0].vaddr_set !== 4'd15) begin errors++; $display("FAIL wrap_first: got %0d want 15", txs_o[0].vaddr_set); end
    send_beat(make_beat(1'b1), ok);
    checks++; if (txs_o[3].vaddr_set !== 4'd0) begin errors++; $display("FAIL wrap_second: got %0d want 0", txs_o[3].vaddr_set); end
    @(negedge clk);
  endtask

  task automatic test_drop_empty;
    bit ok;
    push_info(4'd5, 1'b0, 2'd0, 1'b1, 8'd1, 4'd4, 4'd0, ok);
    send_beat(make_beat(1'b0), ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_accept: got 0 want 1"); end
    checks++;
    if (txs_valid_o !== 4'h0 || busy_o !== 1'b1)
      begin errors++; $display("FAIL drop_no_push: got valid %b busy %b want 0000 1", txs_valid_o, busy_o); end
    send_beat(make_beat(1'b1), ok);
    checks++; if (txs_o[1].vaddr_set !== 4'd5) begin errors++; $display("FAIL drop_advanced: set got %0d want 5", txs_o[1].vaddr_set); end
    #1;
    checks++; if (seq_ready_o !== 1'b0) begin errors++; $display("FAIL drop_dequeued: seq_ready got %b want 0", seq_ready_o); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    bit ok;
    txs_ready = 4'h0;
    push_info(4'd6, 1'b0, 2'd0, 1'b1, 8'd5, 4'd0, 4'd0, ok);
    send_beat(make_beat(1'b1), ok);
    send_beat(make_beat(1'b1), ok);
    push_info(4'd7, 1'b0, 2'd0, 1'b1, 8'd0, 4'd9, 4'd0, ok);
    checks++;
    if (busy_o !== 1'b1 || txs_valid_o !== 4'hF)
      begin errors++; $display("FAIL flush_pre: got busy %b valid %b want 1 1111", busy_o, txs_valid_o); end
    flush = 1'b1;
    #1;
    checks++;
    if (info_ready_o !== 1'b0 || seq_ready_o !== 1'b0)
      begin errors++; $display("FAIL flush_ready_low: got info %b seq %b want 0 0", info_ready_o, seq_ready_o); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || txs_valid_o !== 4'h0 || info_ready_o !== 1'b1)
      begin errors++; $display("FAIL flush_post: got busy %b valid %b info_ready %b want 0 0000 1", busy_o, txs_valid_o, info_ready_o); end
    @(negedge clk);
    txs_ready = 4'hF;
    push_info(4'd8, 1'b0, 2'd0, 1'b1, 8'd0, 4'd7, 4'd0, ok);
    send_beat(make_beat(1'b1), ok);
    checks++;
    if (!ok || txs_o[0].vaddr_set !== 4'd7 || txs_o[0].req_id !== 4'd8)
      begin errors++; $display("FAIL flush_restart: got ok %b set %0d id %0d want 1 7 8", ok, txs_o[0].vaddr_set, txs_o[0].req_id); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    bit ok;
    txs_ready = 4'h0;
    push_info(4'd9, 1'b0, 2'd0, 1'b1, 8'd3, 4'd2, 4'd0, ok);
    send_beat(make_beat(1'b1), ok);
    checks++; if (txs_valid_o !== 4'hF) begin errors++; $display("FAIL arst_pre: got %b want 1111", txs_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (txs_valid_o !== 4'h0 || busy_o !== 1'b0 || seq_ready_o !== 1'b0)
      begin errors++; $display("FAIL arst_clear: got valid %b busy %b seq_ready %b want 0000 0 0", txs_valid_o, busy_o, seq_ready_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    txs_ready = 4'hF;
    repeat (2) @(negedge clk);
    checks++;
    if (info_ready_o !== 1'b1 || txs_valid_o !== 4'h0 || busy_o !== 1'b0)
      begin errors++; $display("FAIL arst_release: got info_ready %b valid %b busy %b want 1 0000 0", info_ready_o, txs_valid_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shuffle();
    test_backpressure();
    test_mask();
    test_wrap();
    test_drop_empty();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
